// File: rtl/uart_pkg.sv
// Shared UART transmit-side definitions: arbiter state encoding, default data width
// and the frame length common to the arbiter and the serializer.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StGap   = 2'd3
    } tx_arb_state_e;

    localparam int unsigned DefaultWidth = 8;
    // Start bit + data bits + stop bit.
    localparam int unsigned FrameBits    = DefaultWidth + 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N-1 -> 0.
// Returns a one-hot grant, its index, and whether any request is present.
module rr_priority_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IdxW = $clog2(N);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        // Scan from the farthest offset down so the nearest request to ptr wins last.
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                idx = IdxW'((int'(ptr) + off) % N);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX serializer among N requesters, one byte per grant.
// Optional WAIT-state watchdog enabled by defining UART_TX_WDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned N           = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned WDOG_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    output logic                 tx_start,
    output logic [WIDTH-1:0]     tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 tx_timeout
);

    localparam int unsigned IdxW    = $clog2(N);
    localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_arb_state_e    state_q, state_d;
    logic [IdxW-1:0]  rr_ptr_q;
    logic [WIDTH-1:0] tx_data_q;
    logic [IdxW-1:0]  grant_id_q;
    logic [GapW-1:0]  gap_q;
    logic             wdog_fire;

    logic [N-1:0]     pick_grant;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;

    rr_priority_picker #(
        .N (N)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef UART_TX_WDOG_EN
    localparam int unsigned WdogW    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int unsigned WdogLast = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;

    logic [WdogW-1:0] wdog_q;
    logic             tx_timeout_q;

    // A tx_done on the final watchdog cycle still counts as a normal completion.
    assign wdog_fire = (state_q == StWait) && !tx_done && (wdog_q == WdogW'(WdogLast));

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q       <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            wdog_q       <= (state_q == StWait && state_d == StWait) ? wdog_q + 1'b1 : '0;
            tx_timeout_q <= wdog_fire;
        end
    end

    assign tx_timeout = tx_timeout_q;
`else
    assign wdog_fire  = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (tx_done || wdog_fire) state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
            StGap:   if (gap_q == GapW'(GapLast)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Data latch, grant bookkeeping and gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            gap_q      <= '0;
        end else begin
            if (state_q == StIdle && pick_any) begin
                tx_data_q  <= req_data[int'(pick_idx) * WIDTH +: WIDTH];
                grant_id_q <= pick_idx;
                rr_ptr_q   <= IdxW'((int'(pick_idx) + 1) % N);
            end
            gap_q <= (state_q == StGap && state_d == StGap) ? gap_q + 1'b1 : '0;
        end
    end

    // Outputs.
    always_comb begin
        req_ready = (state_q == StIdle) ? pick_grant : '0;
        tx_start  = (state_q == StStart);
        busy      = (state_q != StIdle);
        tx_data   = tx_data_q;
        grant_id  = grant_id_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of full transactions plus hand-written
// sequences for reset, stray tx_done and the WAIT watchdog (UART_TX_WDOG_EN).
module tb_uart_tx_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned GAP   = 4;
    localparam int unsigned WDOG  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]     req_ready;
    logic             tx_start;
    logic [WIDTH-1:0] tx_data;
    logic             tx_done;
    logic             busy;
    logic [1:0]       grant_id;
    logic             tx_timeout;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .WIDTH       (WIDTH),
        .N           (N),
        .GAP_CYCLES  (GAP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .tx_timeout (tx_timeout)
    );

    typedef struct {
        bit          rst;        // pulse reset before the vector
        bit          gap_pulse;  // stray tx_done during the gap
        logic [3:0]  valid;
        logic [3:0]  hold;       // req_valid driven after the accept
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        if (v.rst) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        req_data  = v.data;
        req_valid = v.valid;
        #1;
        check($sformatf("v%0d_ready", n), 32'(req_ready), 32'(v.exp_ready));
        if (v.exp_ready == 4'b0000) begin
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", n), 32'(busy), 32'd0);
            return;
        end
        @(negedge clk);
        req_valid = v.hold;
        check($sformatf("v%0d_start", n), 32'(tx_start), 32'd1);
        check($sformatf("v%0d_grant", n), 32'(grant_id), 32'(v.exp_grant));
        check($sformatf("v%0d_data", n), 32'(tx_data), 32'(v.exp_data));
        @(negedge clk);
        check($sformatf("v%0d_wait_start", n), 32'(tx_start), 32'd0);
        check($sformatf("v%0d_wait_ready", n), 32'(req_ready), 32'd0);
        check($sformatf("v%0d_wait_data", n), 32'(tx_data), 32'(v.exp_data));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int k = 0; k < int'(GAP); k++) begin
            check($sformatf("v%0d_gap%0d_busy", n, k), 32'(busy), 32'd1);
            check($sformatf("v%0d_gap%0d_ready", n, k), 32'(req_ready), 32'd0);
            if (v.gap_pulse && k == 1) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (v.gap_pulse) check($sformatf("v%0d_gap%0d_nostart", n, k), 32'(tx_start), 32'd0);
        end
        check($sformatf("v%0d_end_busy", n), 32'(busy), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        bit early;

        //          rst gp valid    hold     data           ready    g     byte
        vecs[0] = '{0, 0, 4'b0100, 4'b0000, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5};
        vecs[1] = '{1, 0, 4'b1111, 4'b1110, 32'h4433_2211, 4'b0001, 2'd0, 8'h11};
        vecs[2] = '{0, 0, 4'b1110, 4'b1100, 32'h4433_2211, 4'b0010, 2'd1, 8'h22};
        vecs[3] = '{0, 0, 4'b1100, 4'b1000, 32'h4433_2211, 4'b0100, 2'd2, 8'h33};
        vecs[4] = '{0, 0, 4'b1001, 4'b0001, 32'h4433_2255, 4'b1000, 2'd3, 8'h44};
        vecs[5] = '{0, 0, 4'b0001, 4'b0000, 32'h4433_2255, 4'b0001, 2'd0, 8'h55};
        vecs[6] = '{0, 0, 4'b0010, 4'b1010, 32'h0000_6600, 4'b0010, 2'd1, 8'h66};
        vecs[7] = '{0, 0, 4'b1010, 4'b0010, 32'h7700_6700, 4'b1000, 2'd3, 8'h77};
        vecs[8] = '{0, 0, 4'b0010, 4'b0000, 32'h0000_6700, 4'b0010, 2'd1, 8'h67};
        vecs[9] = '{0, 0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00};

        reset     = 1'b1;
        tx_done   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(tx_timeout), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Stray tx_done in IDLE.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("idle_done_start2", 32'(tx_start), 32'd0);

        // Stray tx_done in GAP must not shorten or extend the gap (ptr is 2 here).
        run_vec('{0, 1, 4'b0001, 4'b0000, 32'h0000_00E1, 4'b0001, 2'd0, 8'hE1}, 10);

        // Reset during WAIT aborts and restores the pointer to requester 0.
        req_data  = 32'h9900_0000;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0000;
        check("rw_start", 32'(tx_start), 32'd1);
        @(negedge clk);
        check("rw_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_start0", 32'(tx_start), 32'd0);
        check("rw_data", 32'(tx_data), 32'd0);
        check("rw_grant", 32'(grant_id), 32'd0);
        check("rw_ready", 32'(req_ready), 32'd0);
        check("rw_timeout", 32'(tx_timeout), 32'd0);
        run_vec('{0, 0, 4'b1111, 4'b0000, 32'hD4C3_B2A1, 4'b0001, 2'd0, 8'hA1}, 11);

        // Frame whose tx_done never arrives.
        req_data  = 32'h00C3_0000;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        check("wd_start", 32'(tx_start), 32'd1);
        @(negedge clk);
        early = 1'b0;
`ifdef UART_TX_WDOG_EN
        for (int k = 0; k < int'(WDOG); k++) begin
            early |= (tx_timeout !== 1'b0) || (busy !== 1'b1);
            @(negedge clk);
        end
        check("wd_early", 32'(early), 32'd0);
        check("wd_pulse", 32'(tx_timeout), 32'd1);
        check("wd_pulse_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wd_pulse_end", 32'(tx_timeout), 32'd0);
        wait_idle("wd_idle", 2 * int'(GAP));
`else
        for (int k = 0; k < 100; k++) begin
            early |= (tx_timeout !== 1'b0) || (busy !== 1'b1);
            @(negedge clk);
        end
        check("wd_stays_wait", 32'(early), 32'd0);
        check("wd_no_timeout", 32'(tx_timeout), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("wd_gap_busy", 32'(busy), 32'd1);
        wait_idle("wd_idle", 2 * int'(GAP));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
